// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch front end. It holds one outstanding memory |
// |               request and keeps a 2-entry {pc, inst} buffer toward decode. |
// |               Optional macro FETCH_MISALIGN_TRAP_EN enables the held trap  |
// |               on a misaligned redirect.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pause,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [XLEN-1:0]   pc_out,
  output logic [31:0]       inst_out,
  output logic              valid_out,
  output logic              misalign_out
);

  localparam logic [31:0] c_INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_fpc;
  logic [XLEN-1:0]   r_flush_addr;
  logic [XLEN-1:0]   w_redirect_target;
  logic [XLEN-1:0]   r_pc_q   [2];
  logic [31:0]       r_inst_q [2];
  logic              r_head;
  logic [1:0]        r_count;
  logic [1:0]        w_post_count;
  logic              w_tail;
  logic              w_fifo_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_trap;
  logic [XLEN-1:0]   w_head_pc;
  logic [31:0]       w_head_inst;

  assign w_fifo_valid = (r_count != 2'd0);
  assign w_push       = (r_state == S_BUSY) && imem_ack && !redirect;
  assign w_pop        = w_fifo_valid && !pause && !redirect;
  assign w_post_count = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_tail       = r_head ^ (r_count == 2'd1);
  assign w_head_pc    = w_fifo_valid ? r_pc_q[r_head]   : '0;
  assign w_head_inst  = w_fifo_valid ? r_inst_q[r_head] : c_INST_NOP;

  // The flushed request must keep its address even though fpc already moved.
  assign imem_req  = (r_state != S_IDLE);
  assign imem_addr = (r_state == S_FLUSH) ? r_flush_addr : r_fpc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            r_trap;
  logic [XLEN-1:0] r_trap_pc;

  assign w_redirect_target = redirect_pc;
  assign w_trap            = r_trap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_trap    <= 1'b0;
      r_trap_pc <= '0;
    end else if (redirect) begin
      r_trap    <= |redirect_pc[1:0];
      r_trap_pc <= redirect_pc;
    end
  end

  assign valid_out    = (r_trap || w_fifo_valid) && !redirect;
  assign pc_out       = r_trap ? r_trap_pc  : w_head_pc;
  assign inst_out     = r_trap ? c_INST_NOP : w_head_inst;
  assign misalign_out = r_trap;
`else
  assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_trap            = 1'b0;
  assign valid_out         = w_fifo_valid && !redirect;
  assign pc_out            = w_head_pc;
  assign inst_out          = w_head_inst;
  assign misalign_out      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!redirect && !w_trap && (r_count < 2'd2))
          w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (redirect)
          w_state_nxt = imem_ack ? S_IDLE : S_FLUSH;
        else if (imem_ack)
          w_state_nxt = (w_post_count < 2'd2) ? S_BUSY : S_IDLE;
      end
      S_FLUSH: begin
        if (!redirect && imem_ack)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fpc        <= RESET_PC;
      r_flush_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect)
        r_fpc <= w_redirect_target;
      else if (w_push)
        r_fpc <= r_fpc + XLEN'(4);
      if ((r_state == S_BUSY) && redirect && !imem_ack)
        r_flush_addr <= r_fpc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head      <= 1'b0;
      r_count     <= 2'd0;
      r_pc_q[0]   <= '0;
      r_pc_q[1]   <= '0;
      r_inst_q[0] <= c_INST_NOP;
      r_inst_q[1] <= c_INST_NOP;
    end else if (redirect) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc_q[w_tail]   <= r_fpc;
        r_inst_q[w_tail] <= imem_rdata;
      end
      if (w_pop)
        r_head <= ~r_head;
      r_count <= w_post_count;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Directed self-checking bench for fetch_unit.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        pause;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic        misalign_out;
  logic        use_nop;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clock        (clock),
    .reset        (reset),
    .pause        (pause),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .valid_out    (valid_out),
    .misalign_out (misalign_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returns either a plain NOP or a word tagged with its own address.
  assign imem_rdata = use_nop ? 32'h0000_0013 : {8'hA5, imem_addr[23:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      assert (!(dut.w_push && dut.r_count == 2'd2)) else begin
        failures++;
        $error("FAIL push_when_full observed=1 expected=0");
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; use_nop = 1'b1;
    #2;
    chk("rst_req",      {31'b0, imem_req},     32'h0);
    chk("rst_valid",    {31'b0, valid_out},    32'h0);
    chk("rst_pc",       pc_out,                32'h0);
    chk("rst_inst",     inst_out,              32'h13);
    chk("rst_misalign", {31'b0, misalign_out}, 32'h0);

    // Streaming with single-cycle ack
    imem_ack = 1'b1;
    do_reset();
    chk("a_c0_req", {31'b0, imem_req}, 32'h0);
    cyc(); #1;
    chk("a_c1_req",   {31'b0, imem_req},  32'h1);
    chk("a_c1_addr",  imem_addr,          32'h0);
    chk("a_c1_valid", {31'b0, valid_out}, 32'h0);
    cyc(); #1;
    chk("a_c2_valid", {31'b0, valid_out}, 32'h1);
    chk("a_c2_pc",    pc_out,             32'h0);
    chk("a_c2_inst",  inst_out,           32'h13);
    chk("a_c2_addr",  imem_addr,          32'h4);
    cyc(); #1;
    chk("a_c3_pc",   pc_out,    32'h4);
    chk("a_c3_addr", imem_addr, 32'h8);
    cyc(); #1;
    chk("a_c4_pc", pc_out, 32'h8);

    // Pause fills the buffer and stops requesting
    use_nop = 1'b0;
    do_reset();
    cyc(); #1;
    chk("b_c1_addr", imem_addr, 32'h0);
    cyc(); pause = 1'b1; #1;
    chk("b_c2_pc",   pc_out,            32'h0);
    chk("b_c2_req",  {31'b0, imem_req}, 32'h1);
    chk("b_c2_addr", imem_addr,         32'h4);
    cyc(); #1;
    chk("b_c3_req",   {31'b0, imem_req},  32'h0);
    chk("b_c3_pc",    pc_out,             32'h0);
    chk("b_c3_valid", {31'b0, valid_out}, 32'h1);
    cyc(); #1;
    chk("b_c4_req", {31'b0, imem_req}, 32'h0);
    cyc(); #1;
    chk("b_c5_pc",  pc_out,            32'h0);
    chk("b_c5_req", {31'b0, imem_req}, 32'h0);
    cyc(); pause = 1'b0; #1;
    chk("b_c6_pc",    pc_out,             32'h0);
    chk("b_c6_valid", {31'b0, valid_out}, 32'h1);
    cyc(); #1;
    chk("b_c7_pc",   pc_out,            32'h4);
    chk("b_c7_inst", inst_out,          32'hA500_0004);
    chk("b_c7_req",  {31'b0, imem_req}, 32'h0);
    cyc(); #1;
    chk("b_c8_valid", {31'b0, valid_out}, 32'h0);
    chk("b_c8_req",   {31'b0, imem_req},  32'h1);
    chk("b_c8_addr",  imem_addr,          32'h8);
    cyc(); #1;
    chk("b_c9_pc",    pc_out,             32'h8);
    chk("b_c9_valid", {31'b0, valid_out}, 32'h1);

    // Redirect while a request waits for a late ack
    do_reset();
    cyc(); #1;
    cyc(); #1;
    chk("c_c2_pc", pc_out, 32'h0);
    cyc(); imem_ack = 1'b0; #1;
    chk("c_c3_addr", imem_addr, 32'h8);
    chk("c_c3_pc",   pc_out,    32'h4);
    cyc(); redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("c_c4_valid", {31'b0, valid_out}, 32'h0);
    chk("c_c4_addr",  imem_addr,          32'h8);
    cyc(); redirect = 1'b0; #1;
    chk("c_c5_req",   {31'b0, imem_req},  32'h1);
    chk("c_c5_addr",  imem_addr,          32'h8);
    chk("c_c5_valid", {31'b0, valid_out}, 32'h0);
    cyc(); imem_ack = 1'b1; #1;
    chk("c_c6_addr",  imem_addr,          32'h8);
    chk("c_c6_valid", {31'b0, valid_out}, 32'h0);
    cyc(); #1;
    chk("c_c7_req",   {31'b0, imem_req},  32'h0);
    chk("c_c7_valid", {31'b0, valid_out}, 32'h0);
    cyc(); #1;
    chk("c_c8_addr",  imem_addr,          32'h100);
    chk("c_c8_valid", {31'b0, valid_out}, 32'h0);
    cyc(); #1;
    chk("c_c9_valid", {31'b0, valid_out}, 32'h1);
    chk("c_c9_pc",    pc_out,             32'h100);

    // Redirect coinciding with ack and pop
    do_reset();
    cyc(); #1;
    cyc(); redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("d_c2_valid", {31'b0, valid_out}, 32'h0);
    chk("d_c2_addr",  imem_addr,          32'h4);
    cyc(); redirect = 1'b0; #1;
    chk("d_c3_req",   {31'b0, imem_req},  32'h0);
    chk("d_c3_valid", {31'b0, valid_out}, 32'h0);
    cyc(); #1;
    chk("d_c4_addr", imem_addr, 32'h200);
    cyc(); #1;
    chk("d_c5_pc",   pc_out,   32'h200);
    chk("d_c5_inst", inst_out, 32'hA500_0200);

    // Reset pulse abandons an outstanding request
    imem_ack = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h40; #1;
    cyc(); redirect = 1'b0; #1;
    chk("e_c1_req", {31'b0, imem_req}, 32'h0);
    cyc(); #1;
    chk("e_c2_req",  {31'b0, imem_req}, 32'h1);
    chk("e_c2_addr", imem_addr,         32'h40);
    reset = 1'b1; #1;
    chk("e_rst_req",   {31'b0, imem_req},  32'h0);
    chk("e_rst_valid", {31'b0, valid_out}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; imem_ack = 1'b1; #1;
    chk("e_c0_req", {31'b0, imem_req}, 32'h0);
    cyc(); #1;
    chk("e_c1_req2",  {31'b0, imem_req}, 32'h1);
    chk("e_c1_addr2", imem_addr,         32'h0);

    // Misaligned redirect target
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h102; #1;
    chk("f_c0_valid", {31'b0, valid_out}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    cyc(); redirect = 1'b0; #1;
    chk("f_c1_misalign", {31'b0, misalign_out}, 32'h1);
    chk("f_c1_pc",       pc_out,                32'h102);
    chk("f_c1_valid",    {31'b0, valid_out},    32'h1);
    chk("f_c1_req",      {31'b0, imem_req},     32'h0);
    chk("f_c1_inst",     inst_out,              32'h13);
    cyc(); #1;
    chk("f_c2_req",      {31'b0, imem_req},     32'h0);
    chk("f_c2_misalign", {31'b0, misalign_out}, 32'h1);
    chk("f_c2_pc",       pc_out,                32'h102);
    cyc(); redirect = 1'b1; redirect_pc = 32'h104; #1;
    chk("f_c3_valid", {31'b0, valid_out}, 32'h0);
    cyc(); redirect = 1'b0; #1;
    chk("f_c4_misalign", {31'b0, misalign_out}, 32'h0);
    chk("f_c4_req",      {31'b0, imem_req},     32'h0);
    cyc(); #1;
    chk("f_c5_addr", imem_addr,         32'h104);
    chk("f_c5_req",  {31'b0, imem_req}, 32'h1);
`else
    cyc(); redirect = 1'b0; #1;
    chk("f_c1_req",      {31'b0, imem_req},     32'h0);
    chk("f_c1_misalign", {31'b0, misalign_out}, 32'h0);
    cyc(); #1;
    chk("f_c2_addr",     imem_addr,             32'h100);
    chk("f_c2_misalign", {31'b0, misalign_out}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters: XLEN, 32, datapath width; RESET_PC, 0, first fetch address.
REQ-002 SHALL have ports: clock  in  1  rising-edge clock; reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: pause  in  1  downstream hold (no pop); redirect  in  1  flush and restart fetch; redirect_pc  in  XLEN  restart target.
REQ-004 SHALL have ports: imem_req  out  1  request valid; imem_addr  out  XLEN  word address; imem_ack  in  1  response (same cycle as req allowed); imem_rdata  in  32  instruction on ack.
REQ-005 SHALL have ports: pc_out  out  XLEN; inst_out  out  32; valid_out  out  1  (if_id bubble = ~valid_out); misalign_out  out  1.

Function
REQ-006 SHALL hold a 2-entry FIFO of {pc, inst}; head drives pc_out/inst_out; valid_out = FIFO non-empty AND ~redirect.
REQ-007 SHALL pop head on a cycle with valid_out=1 and pause=0; pause SHALL NOT stop fetching.
REQ-008 SHALL keep fetch PC fpc, next request address; imem_addr = fpc; fpc += 4 on each non-discarded ack.
REQ-009 SHALL implement states IDLE (no request), BUSY (request outstanding), FLUSH (request outstanding, response to discard).
REQ-010 SHALL hold imem_req=1 and imem_addr stable in BUSY/FLUSH until imem_ack; imem_req=0 in IDLE.
REQ-011 IDLE -> BUSY when FIFO count < 2 and no redirect; at most one request outstanding.
REQ-012 BUSY with ack, no redirect: push {fpc, imem_rdata}; stay BUSY if post-update count < 2, else IDLE; one-cycle ack gives 1 instruction/cycle.
REQ-013 redirect in any state: FIFO cleared that cycle; fpc <= redirect_pc; a simultaneous pop is dropped.
REQ-014 redirect in BUSY without ack -> FLUSH; with ack -> IDLE, data discarded; in IDLE -> IDLE; in FLUSH -> FLUSH.
REQ-015 FLUSH with ack: discard data, no push, no fpc change -> IDLE; new request issued the next cycle.
REQ-016 push when full SHALL be impossible by REQ-011/012; bench SHALL assert it.
REQ-017 When FIFO empty: pc_out=0, inst_out=INST_NOP, valid_out=0.
REQ-018 fpc wraps modulo 2^XLEN without flag.

Reset
REQ-019 reset=1 SHALL immediately: state IDLE, fpc=RESET_PC, FIFO empty, imem_req=0, valid_out=0, misalign_out=0, pc_out=0, inst_out=INST_NOP.
REQ-020 reset asserted mid-request SHALL abandon it; first request SHALL issue the first clock after reset deasserts.

Configuration
REQ-021 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 enters a held trap: FIFO cleared, no requests, valid_out=1, pc_out=redirect_pc, inst_out=INST_NOP, misalign_out=1, ignores pops, until next aligned redirect or reset.
REQ-022 Macro undefined: redirect_pc[1:0] forced to 0; misalign_out tied 0; port kept.

Verification
REQ-023 reset release, ack every cycle, rdata=0x00000013 -> imem_addr 0,4,8 on consecutive cycles; valid_out from cycle 2; pc_out 0,4,8.
REQ-024 pause=1 for 4 cycles, ack every cycle -> FIFO fills to 2, imem_req drops; pc_out stays 0x0 until pause released, then 0x4, 0x8 in order.
REQ-025 redirect to 0x100 while req at 0x8 awaits ack (ack 3 cycles later) -> that response discarded, next imem_addr 0x100, valid_out=0 until 0x100 returns.
REQ-026 redirect to 0x200 on same cycle as ack and pop -> no push, valid_out=0 that cycle, next imem_addr 0x200.
REQ-027 reset pulsed while BUSY at 0x40 -> imem_req=0 immediately, next request at RESET_PC.
REQ-028 macro on, redirect to 0x102 -> misalign_out=1, pc_out=0x102, imem_req=0; redirect to 0x104 -> misalign_out=0, fetch resumes at 0x104.
